// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue.
// - state_e: sequencer states, 2-bit encoding.
// - DefWidth / DefAddrWidth: default word width and FIFO address width. DefWidth matches the
//   receiver/transmitter Nbits.
package uart_tx_queue_pkg;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefAddrWidth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StStart = 2'd2,
        StWait  = 2'd3
    } state_e;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Circular FIFO: 2**AddrWidth words of Width bits. It also keeps a sticky overflow flag.
// Ports:
//   clk_i, rst_i       clock; synchronous active-high reset
//   wr_en_i, wr_data_i push strobe and the word to push
//   rd_en_i            pop strobe. It is ignored while the FIFO is empty.
//   ovf_clr_i          clears the overflow flag
//   rd_data_o          word at the read pointer (combinational)
//   full_o, empty_o    status flags derived from the registered count
//   count_o            number of stored words
//   overflow_o         sticky flag: a push was dropped because the FIFO was full
module uart_tx_queue_sync_fifo #(
    parameter int unsigned Width     = 8,
    parameter int unsigned AddrWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [Width-1:0]     wr_data_i,
    input  logic                 rd_en_i,
    input  logic                 ovf_clr_i,
    output logic [Width-1:0]     rd_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AddrWidth:0]   count_o,
    output logic                 overflow_o
);

    localparam int unsigned        Depth     = 2 ** AddrWidth;
    localparam logic [AddrWidth:0] FullCount = {1'b1, {AddrWidth{1'b0}}};

    logic [Width-1:0]     mem_q [Depth];
    logic [AddrWidth-1:0] wr_ptr_q;
    logic [AddrWidth-1:0] rd_ptr_q;
    logic [AddrWidth:0]   count_q;
    logic                 overflow_q;
    logic                 push;
    logic                 pop;

    assign full_o     = (count_q == FullCount);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    assign pop  = rd_en_i && !empty_o;
    // A pop in the same cycle makes room, so a full FIFO still accepts the push.
    assign push = wr_en_i && (!full_o || pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // When a drop and a clear happen in the same cycle, the set takes priority.
            if (wr_en_i && !push) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage has no reset. Contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Elastic byte queue between the UART receiver and the UART transmitter.
// Received bytes are pushed on wr_en_i. The sequencer drains them one at a time using the
// transmitter's start/end-of-transmission handshake.
// Ports:
//   clk_i, rst_i           clock; synchronous active-high reset
//   wr_en_i, wr_data_i     push strobe (receiver end-of-reception) and the byte to push
//   tx_eot_i               end-of-transmission pulse from the transmitter
//   ovf_clr_i              clears the sticky overflow flag
//   tx_stt_o               one-cycle start pulse to the transmitter
//   tx_data_o              byte to transmit; held from tx_stt_o until tx_eot_i
//   full_o, empty_o        FIFO status
//   count_o                words stored in the FIFO (excludes the byte in flight)
//   overflow_o             sticky flag: a push was dropped
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int unsigned Width     = DefWidth,
    parameter int unsigned AddrWidth = DefAddrWidth
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [Width-1:0]   wr_data_i,
    input  logic               tx_eot_i,
    input  logic               ovf_clr_i,
    output logic               tx_stt_o,
    output logic [Width-1:0]   tx_data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [AddrWidth:0] count_o,
    output logic               overflow_o
);

    state_e           state_q;
    state_e           state_d;
    logic             rd_en;
    logic             fifo_empty;
    logic [Width-1:0] rd_data;
    logic [Width-1:0] tx_data_q;
    logic             tx_stt_q;

    uart_tx_queue_sync_fifo #(
        .Width     (Width),
        .AddrWidth (AddrWidth)
    ) u_sync_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .rd_en_i    (rd_en),
        .ovf_clr_i  (ovf_clr_i),
        .rd_data_o  (rd_data),
        .full_o     (full_o),
        .empty_o    (fifo_empty),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    assign empty_o   = fifo_empty;
    assign tx_data_o = tx_data_q;
    assign tx_stt_o  = tx_stt_q;

    // tx_eot_i is only honoured in StWait. Pulses in any other state are ignored.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StStart;
            StStart: state_d = StWait;
            StWait: begin
                if (tx_eot_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            tx_data_q <= '0;
            tx_stt_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Registered copy of "in StStart": the start pulse comes straight from a flop.
            tx_stt_q <= (state_d == StStart);
            if (rd_en) begin
                tx_data_q <= rd_data;
            end
        end
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Elastic byte queue plus transmit sequencer between the UART receiver and the UART transmitter.
- Accepts each received byte on the receiver's end-of-reception pulse and stores it in a circular FIFO.
- Drains the FIFO into the transmitter one byte at a time using its start/end-of-transmission handshake, so bursts arriving back-to-back on rx are not lost while tx is busy.

Parameters:
- Width, 8, data bits per word (matches receiver/transmitter Nbits).
- AddrWidth, 4, FIFO address bits; depth = 2**AddrWidth = 16 words.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- wr_en_i  input  1  push strobe, one-cycle pulse (receiver eor_o).
- wr_data_i  input  Width  byte to push, valid while wr_en_i=1.
- tx_eot_i  input  1  end-of-transmission pulse from transmitter.
- ovf_clr_i  input  1  clears sticky overflow flag.
- tx_stt_o  output  1  start pulse to transmitter, exactly one cycle.
- tx_data_o  output  Width  byte to transmitter, stable from tx_stt_o until tx_eot_i.
- full_o  output  1  count == 2**AddrWidth.
- empty_o  output  1  count == 0.
- count_o  output  AddrWidth+1  words stored.
- overflow_o  output  1  sticky: a push was dropped.

Behaviour:
- Reset (rst_i=1 at a rising edge): wr/rd pointers=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, tx_stt_o=0, tx_data_o=0, FSM=IDLE. Reset mid-transfer discards queue contents and any byte in flight; no tx_stt_o in the reset cycle or the cycle after.
- FIFO storage: 2**AddrWidth x Width register array. Pointers are AddrWidth bits and wrap modulo depth (15 -> 0). count_o is registered.
- Push: when wr_en_i=1 and (!full_o or pop this cycle), write mem[wr_ptr] and increment wr_ptr.
- Push when full with no pop: the byte is dropped and overflow_o is set to 1. overflow_o stays high until ovf_clr_i=1; if a drop and ovf_clr_i coincide, set wins.
- Pop: internal rd_en, issued only in IDLE when !empty_o. tx_data_o <= mem[rd_ptr]; rd_ptr increments.
- Count update: push only +1; pop only -1; both accepted in the same cycle leaves count unchanged. Push and pop on a full FIFO are both accepted.
- FSM states:
  - IDLE: if !empty_o, pop and go LOAD; else stay.
  - LOAD: tx_data_o now valid; go START.
  - START: tx_stt_o=1 for this cycle only; go WAIT.
  - WAIT: hold tx_data_o; on tx_eot_i=1 go IDLE.
- tx_eot_i in IDLE, LOAD or START is ignored.
- Latency: push at edge t into an empty idle queue gives empty_o=0 after t; pop at t+1; tx_stt_o high during cycle t+3. Back-to-back bytes: next tx_stt_o follows 3 cycles after tx_eot_i.
- tx_stt_o is registered (Moore output of START); never high two consecutive cycles.

Decomposition:
- Shared package: FSM state encoding (IDLE, LOAD, START, WAIT as 2-bit constants) and default Width/AddrWidth constants, shared with receiver/transmitter Nbits.
- One sub-module: sync_fifo. It contains pointers, count, full/empty, storage and the overflow flag, and exposes wr_en/rd_en. The sequencer FSM lives in uart_tx_queue.

Test Plan:
- Reset: hold rst_i 2 cycles with wr_en_i pulsing -> count_o=0, empty_o=1, overflow_o=0, tx_stt_o=0, no write retained.
- Single byte: push 8'hA5 at cycle 0 -> tx_stt_o=1 only in cycle 3, tx_data_o=8'hA5 held until tx_eot_i pulse at cycle 200; then empty_o=1, FSM IDLE, no further stt.
- Burst ordering: push 8'h01..8'h05 on consecutive cycles, model tx_eot_i 160 cycles after each stt -> five stt pulses with tx_data_o 01,02,03,04,05 in order; count_o peaks at 4 (first pops immediately).
- Full/overflow: with tx_eot_i held 0 after first stt, push 17 more bytes -> count_o=16, full_o=1, 18th push dropped, overflow_o=1; ovf_clr_i pulse -> overflow_o=0.
- Wrap-around plus simultaneous push/pop on full: cycle 40 bytes through with random tx_eot_i delay (pointers wrap twice), and push in the same cycle as a pop while full -> all bytes emitted in order, count_o stays 16, overflow_o=0.
- Reset mid-operation: assert rst_i during WAIT with 6 bytes queued -> next cycle count_o=0, tx_data_o=0; later tx_eot_i ignored; new push 8'h3C is sent as the first byte.
